// File: rtl/acc_feeder_pkg.sv
// acc_feeder_pkg
//   Shared definitions for the accelerator operand feeder: FSM state
//   encoding, default lane counts/widths and a small state-decode helper.
package acc_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IFM_LANES  = 9;
  localparam int DEF_WGT_LANES  = 9;
  localparam int DEF_BIAS_BYTES = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int CNT_W          = 8;   // element counter width, lanes < 256

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_WGT  = 3'd2,
    ST_IFM  = 3'd3,
    ST_FIRE = 3'd4,
    ST_DONE = 3'd5
  } feeder_state_e;

  function automatic logic state_is_busy(feeder_state_e s);
    return (s == ST_BIAS) || (s == ST_WGT) || (s == ST_IFM) || (s == ST_FIRE);
  endfunction

endpackage

// File: rtl/acc_feeder_rd_port.sv
// feeder_rd_port
//   Single-outstanding memory read port. Owns the request/address/valid
//   handshake and the pending flag.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     issue_i, issue_addr_i      launch a read (only when idle or on rsp_valid_o)
//     mem_rd_req_o, mem_rd_addr_o request, held until the matching valid
//     mem_rd_valid_i, mem_rd_data_i  memory response
//     rsp_valid_o, rsp_data_o    response qualified by a pending request
module feeder_rd_port
  import acc_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  output logic                  mem_rd_req_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic                  mem_rd_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o
);

  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // A valid with nothing pending is dropped here, so the FSM never sees it.
  assign rsp_valid_o = mem_rd_valid_i & pending_q;
  assign rsp_data_o  = mem_rd_data_i;

  // Re-issuing in the response cycle keeps the port busy back-to-back; the
  // new address only appears on the bus from the following cycle.
  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    if (issue_i) begin
      pending_d = 1'b1;
      addr_d    = issue_addr_i;
    end else if (rsp_valid_o) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
    end
  end

  assign mem_rd_req_o  = pending_q;
  assign mem_rd_addr_o = pending_q ? addr_q : '0;

endmodule

// File: rtl/acc_feeder.sv
// acc_feeder
//   Fetches a bias word, a weight vector and a sequence of IFM windows from
//   memory and presents them to the accelerator with a one-cycle acc_start.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     cfg_start, cfg_base_wgt,
//     cfg_base_ifm, cfg_num_windows       job configuration (sampled in IDLE)
//     mem_rd_req/addr, mem_rd_valid/data  memory read handshake
//     acc_start, bias_out, wgt_out,
//     ifm_out                             accelerator operands (lane 0 at LSB)
//     busy, done                          job status
//
//   state | meaning
//   IDLE  | waiting for cfg_start
//   BIAS  | fetching BIAS_BYTES bias elements, little-endian
//   WGT   | fetching WGT_LANES weight elements
//   IFM   | fetching IFM_LANES elements of the current window into the shadow
//   FIRE  | one cycle, acc_start=1, operands just loaded from the shadows
//   DONE  | one cycle completion pulse
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IFM_LANES  = DEF_IFM_LANES,
  parameter int WGT_LANES  = DEF_WGT_LANES,
  parameter int BIAS_BYTES = DEF_BIAS_BYTES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_wgt,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_ifm,
  input  logic [15:0]                      cfg_num_windows,
  output logic                             mem_rd_req,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic                             mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic                             acc_start,
  output logic [DATA_WIDTH*BIAS_BYTES-1:0] bias_out,
  output logic [DATA_WIDTH*WGT_LANES-1:0]  wgt_out,
  output logic [DATA_WIDTH*IFM_LANES-1:0]  ifm_out,
  output logic                             busy,
  output logic                             done
);

  localparam logic [CNT_W-1:0] BIAS_LAST = CNT_W'(BIAS_BYTES - 1);
  localparam logic [CNT_W-1:0] WGT_LAST  = CNT_W'(WGT_LANES - 1);
  localparam logic [CNT_W-1:0] IFM_LAST  = CNT_W'(IFM_LANES - 1);

  feeder_state_e state_q, state_d;

  logic [CNT_W-1:0]      elem_q, elem_d;
  logic [15:0]           win_q, win_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] base_ifm_q;
  logic [15:0]           num_win_q;
  logic                  lat_cfg;

  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [DATA_WIDTH*BIAS_BYTES-1:0] bias_sh_q, bias_q;
  logic [DATA_WIDTH*WGT_LANES-1:0]  wgt_sh_q, wgt_q;
  logic [DATA_WIDTH*IFM_LANES-1:0]  ifm_sh_q, ifm_q, ifm_nxt;

  feeder_rd_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_port (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_i        (issue),
    .issue_addr_i   (issue_addr),
    .mem_rd_req_o   (mem_rd_req),
    .mem_rd_addr_o  (mem_rd_addr),
    .mem_rd_valid_i (mem_rd_valid),
    .mem_rd_data_i  (mem_rd_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_data_o     (rsp_data)
  );

  // Bias and weights are one contiguous run from cfg_base_wgt, and the IFM
  // windows are one contiguous run from cfg_base_ifm, so a single pointer
  // walks both. Each next read is launched in the cycle its predecessor
  // returns; FIRE launches the first read of the following window.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    issue      = 1'b0;
    issue_addr = ptr_q;
    lat_cfg    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d    = ST_BIAS;
          lat_cfg    = 1'b1;
          issue      = 1'b1;
          issue_addr = cfg_base_wgt;
          ptr_d      = cfg_base_wgt + 1'b1;
          elem_d     = '0;
          win_d      = '0;
        end
      end
      ST_BIAS: begin
        if (rsp_valid) begin
          issue = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (elem_q == BIAS_LAST) begin
            state_d = ST_WGT;
            elem_d  = '0;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      ST_WGT: begin
        if (rsp_valid) begin
          if (elem_q == WGT_LAST) begin
            elem_d = '0;
            if (num_win_q == 16'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_IFM;
              issue      = 1'b1;
              issue_addr = base_ifm_q;
              ptr_d      = base_ifm_q + 1'b1;
            end
          end else begin
            issue  = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            elem_d = elem_q + 1'b1;
          end
        end
      end
      ST_IFM: begin
        if (rsp_valid) begin
          if (elem_q == IFM_LAST) begin
            state_d = ST_FIRE;
            elem_d  = '0;
          end else begin
            issue  = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            elem_d = elem_q + 1'b1;
          end
        end
      end
      ST_FIRE: begin
        win_d = win_q + 16'd1;
        if (win_q + 16'd1 == num_win_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IFM;
          issue   = 1'b1;
          ptr_d   = ptr_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // IFM shadow with the arriving element merged in; the last element of a
  // window lands in the shadow and on ifm_out on the same edge.
  always_comb begin
    ifm_nxt = ifm_sh_q;
    if (rsp_valid && state_q == ST_IFM) begin
      for (int i = 0; i < IFM_LANES; i++) begin
        if (elem_q == CNT_W'(i)) ifm_nxt[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      elem_q     <= '0;
      win_q      <= '0;
      ptr_q      <= '0;
      base_ifm_q <= '0;
      num_win_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      if (lat_cfg) begin
        base_ifm_q <= cfg_base_ifm;
        num_win_q  <= cfg_num_windows;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_sh_q <= '0;
      wgt_sh_q  <= '0;
      ifm_sh_q  <= '0;
      bias_q    <= '0;
      wgt_q     <= '0;
      ifm_q     <= '0;
    end else begin
      if (rsp_valid && state_q == ST_BIAS) begin
        for (int i = 0; i < BIAS_BYTES; i++) begin
          if (elem_q == CNT_W'(i)) bias_sh_q[i*DATA_WIDTH +: DATA_WIDTH] <= rsp_data;
        end
      end
      if (rsp_valid && state_q == ST_WGT) begin
        for (int i = 0; i < WGT_LANES; i++) begin
          if (elem_q == CNT_W'(i)) wgt_sh_q[i*DATA_WIDTH +: DATA_WIDTH] <= rsp_data;
        end
      end
      if (rsp_valid && state_q == ST_IFM) ifm_sh_q <= ifm_nxt;
      if (state_q == ST_IFM && state_d == ST_FIRE) begin
        ifm_q  <= ifm_nxt;
        wgt_q  <= wgt_sh_q;
        bias_q <= bias_sh_q;
      end
    end
  end

  assign acc_start = (state_q == ST_FIRE);
  assign done      = (state_q == ST_DONE);
  assign busy      = state_is_busy(state_q);
  assign bias_out  = bias_q;
  assign wgt_out   = wgt_q;
  assign ifm_out   = ifm_q;

endmodule

// File: tb/tb_acc_feeder.sv
module tb_acc_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [15:0] cfg_base_wgt, cfg_base_ifm, cfg_num_windows;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        acc_start;
  logic [31:0] bias_out;
  logic [71:0] wgt_out, ifm_out;
  logic        busy, done;

  always #5 clk = ~clk;

  acc_feeder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_base_wgt    (cfg_base_wgt),
    .cfg_base_ifm    (cfg_base_ifm),
    .cfg_num_windows (cfg_num_windows),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .acc_start       (acc_start),
    .bias_out        (bias_out),
    .wgt_out         (wgt_out),
    .ifm_out         (ifm_out),
    .busy            (busy),
    .done            (done)
  );

  int checks = 0;
  int errors = 0;

  // memory responder state
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [$];
  int          lat = 1;
  int          hold_err = 0;
  logic        spur_pending = 1'b0;
  logic        serving = 1'b0;
  int          cnt = 0;
  logic [15:0] cur_addr = '0;

  // monitor state
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          chg_err = 0;
  logic        busy_at_done = 1'b0;
  int          fire_cyc [0:3];
  logic [71:0] ifm_snap [0:3];
  logic [175:0] prev_ops = '0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory with latency lat: valid is seen by the DUT lat cycles after req.
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = a[7:0];
    for (int a = 0; a < 4; a++) mem[a] = 8'(a + 1);
    for (int a = 0; a < 9; a++) mem[a + 4] = 8'(a + 1);
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        serving      = 1'b0;
        mem_rd_valid = 1'b0;
      end else begin
        if (mem_rd_valid) begin
          mem_rd_valid = 1'b0;
          serving      = 1'b0;
        end else if (serving) begin
          if (mem_rd_req !== 1'b1 || mem_rd_addr !== cur_addr) hold_err++;
          cnt--;
          if (cnt == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem[cur_addr];
          end
        end
        if (!serving && !mem_rd_valid && mem_rd_req === 1'b1) begin
          serving  = 1'b1;
          cnt      = lat;
          cur_addr = mem_rd_addr;
          addr_log.push_back(mem_rd_addr);
        end else if (!serving && !mem_rd_valid && spur_pending) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = 8'hEE;
          spur_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (acc_start) begin
          if (acc_cnt < 4) begin
            fire_cyc[acc_cnt] = cyc;
            ifm_snap[acc_cnt] = ifm_out;
          end
          acc_cnt++;
        end else if ({bias_out, wgt_out, ifm_out} !== prev_ops) begin
          chg_err++;
        end
        if (done) begin
          done_cnt++;
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
      prev_ops = {bias_out, wgt_out, ifm_out};
    end
  end

  task automatic clear_stats();
    addr_log.delete();
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [15:0] bw, input logic [15:0] bi, input logic [15:0] nw);
    clear_stats();
    cfg_base_wgt    = bw;
    cfg_base_ifm    = bi;
    cfg_num_windows = nw;
    cfg_start       = 1'b1;
    tick();
    cfg_start       = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_finished"}, {71'd0, ok}, 72'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    cfg_start       = 1'b0;
    cfg_base_wgt    = '0;
    cfg_base_ifm    = '0;
    cfg_num_windows = '0;
    #12;
    chk("rst_bias", {40'd0, bias_out}, 72'd0);
    chk("rst_wgt", wgt_out, 72'd0);
    chk("rst_ifm", ifm_out, 72'd0);
    chk("rst_ctl", {68'd0, busy, done, acc_start, mem_rd_req}, 72'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // two windows, latency 1
    lat = 1;
    start_job(16'h0000, 16'h0100, 16'd2);
    chk("t1_busy", {71'd0, busy}, 72'd1);
    wait_done("t1");
    chk("t1_bias", {40'd0, bias_out}, {40'd0, 32'h04030201});
    chk("t1_wgt", wgt_out, 72'h090807060504030201);
    chk("t1_acc_cnt", 72'(acc_cnt), 72'd2);
    chk("t1_ifm_w0", ifm_snap[0], 72'h080706050403020100);
    chk("t1_ifm_w1", ifm_snap[1], 72'h11100F0E0D0C0B0A09);
    chk("t1_ifm_hold", ifm_out, 72'h11100F0E0D0C0B0A09);
    chk("t1_done_gap", 72'(done_cyc - fire_cyc[1]), 72'd1);
    chk("t1_period_min", {71'd0, (fire_cyc[1] - fire_cyc[0]) >= 19}, 72'd1);
    chk("t1_busy_at_done", {71'd0, busy_at_done}, 72'd0);
    chk("t1_nreads", 72'(addr_log.size()), 72'd31);
    chk("t1_addr12", {56'd0, addr_log[12]}, 72'h000C);
    chk("t1_addr13", {56'd0, addr_log[13]}, 72'h0100);
    chk("t1_addr30", {56'd0, addr_log[30]}, 72'h0111);
    tick();
    chk("t1_done_len", 72'(done_cnt), 72'd1);
    chk("t1_idle", {70'd0, busy, done}, 72'd0);

    // zero windows
    start_job(16'h0000, 16'h0100, 16'd0);
    wait_done("t2");
    tick();
    chk("t2_nreads", 72'(addr_log.size()), 72'd13);
    chk("t2_acc_cnt", 72'(acc_cnt), 72'd0);
    chk("t2_done_cnt", 72'(done_cnt), 72'd1);
    chk("t2_bias_hold", {40'd0, bias_out}, {40'd0, 32'h04030201});

    // IFM address wrap
    start_job(16'h0200, 16'hFFFC, 16'd1);
    wait_done("t3");
    chk("t3_nreads", 72'(addr_log.size()), 72'd22);
    chk("t3_addr_ffff", {56'd0, addr_log[16]}, 72'hFFFF);
    chk("t3_addr_0000", {56'd0, addr_log[17]}, 72'h0000);
    chk("t3_addr_0004", {56'd0, addr_log[21]}, 72'h0004);
    chk("t3_ifm", ifm_out, 72'h0104030201FFFEFDFC);
    chk("t3_bias", {40'd0, bias_out}, {40'd0, 32'h03020100});
    chk("t3_wgt", wgt_out, 72'h0C0B0A090807060504);
    tick();

    // latency 3, spurious valid while idle, second start mid-job
    lat = 3;
    clear_stats();
    spur_pending = 1'b1;
    repeat (4) tick();
    chk("t4_spur_idle", {70'd0, busy, mem_rd_req}, 72'd0);
    chk("t4_spur_bias", {40'd0, bias_out}, {40'd0, 32'h03020100});
    start_job(16'h0000, 16'h0100, 16'd1);
    repeat (10) tick();
    cfg_base_wgt    = 16'h0200;
    cfg_base_ifm    = 16'h0300;
    cfg_num_windows = 16'd5;
    cfg_start       = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done("t4");
    chk("t4_bias", {40'd0, bias_out}, {40'd0, 32'h04030201});
    chk("t4_wgt", wgt_out, 72'h090807060504030201);
    chk("t4_ifm", ifm_out, 72'h080706050403020100);
    chk("t4_acc_cnt", 72'(acc_cnt), 72'd1);
    chk("t4_addr0", {56'd0, addr_log[0]}, 72'h0000);
    repeat (20) tick();
    chk("t4_nreads", 72'(addr_log.size()), 72'd22);
    chk("t4_no_restart", {71'd0, busy}, 72'd0);

    // reset during window 1 fetch
    lat = 1;
    start_job(16'h0000, 16'h0100, 16'd2);
    for (int i = 0; i < 500 && acc_cnt == 0; i++) tick();
    chk("t5_first_fire", 72'(acc_cnt), 72'd1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_bias", {40'd0, bias_out}, 72'd0);
    chk("t5_rst_wgt", wgt_out, 72'd0);
    chk("t5_rst_ifm", ifm_out, 72'd0);
    chk("t5_rst_ctl", {68'd0, busy, done, acc_start, mem_rd_req}, 72'd0);
    chk("t5_rst_addr", {56'd0, mem_rd_addr}, 72'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_job(16'h0200, 16'hFFFC, 16'd1);
    wait_done("t5");
    chk("t5_ifm", ifm_out, 72'h0104030201FFFEFDFC);
    chk("t5_bias", {40'd0, bias_out}, {40'd0, 32'h03020100});
    chk("t5_nreads", 72'(addr_log.size()), 72'd22);

    chk("hold_errors", 72'(hold_err), 72'd0);
    chk("output_changes", 72'(chg_err), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
